// File: rtl/perf_pkg.sv
// Shared types and constants for the performance event router.
// Config layout is the software-visible CFG register format.
package perf_pkg;

  localparam int PERF_MAX_SOURCES = 256;
  localparam int PERF_REG_STRIDE  = 4;

  localparam int PERF_SEL_LSB  = 0;
  localparam int PERF_SEL_W    = 8;
  localparam int PERF_EN_BIT   = 8;
  localparam int PERF_EDGE_BIT = 9;
  localparam int PERF_INV_BIT  = 10;
  localparam int PERF_CFG_W    = 11;

  localparam int PERF_CTRL_FREEZE_BIT = 0;

  typedef struct packed {
    logic                  inv;
    logic                  edge_mode;
    logic                  en;
    logic [PERF_SEL_W-1:0] sel;
  } perf_cfg_t;

  function automatic logic [31:0] perf_cfg_word(
    input perf_cfg_t cfg
  );
    return 32'(cfg);
  endfunction

  function automatic perf_cfg_t perf_cfg_from_word(
    input logic [PERF_CFG_W-1:0] w
  );
    return perf_cfg_t'(w);
  endfunction

endpackage

// File: rtl/perf_event_channel.sv
// One counter channel: selects a source, qualifies it as
// level/edge/inverted and registers the resulting event bit.
module perf_event_channel
  import perf_pkg::*;
#(
  parameter int NUM_SOURCES = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_SOURCES-1:0] src_i,
  input  logic                   cfg_we_i,
  input  perf_cfg_t              cfg_wdata_i,
  input  logic                   freeze_i,
  output perf_cfg_t              cfg_o,
  output logic                   event_o
);

  perf_cfg_t cfg_q, cfg_d;
  logic      hist_q, hist_d;
  logic      prime_q, prime_d;
  logic      event_q, event_d;

  logic [PERF_MAX_SOURCES-1:0] src_ext;
  logic                        raw;
  logic                        v;
  logic                        hit;

  // Zero padding makes any sel >= NUM_SOURCES read as 0.
  always_comb begin
    src_ext = '0;
    src_ext[NUM_SOURCES-1:0] = src_i;
    raw = src_ext[cfg_q.sel];
    v   = raw ^ cfg_q.inv;
  end

  always_comb begin
    hit = cfg_q.edge_mode ? (v & ~hist_q) : v;
    if (prime_q) begin
      hit = 1'b0;
    end
  end

  // History tracks every cycle, including while frozen or primed.
  always_comb begin
    cfg_d   = cfg_q;
    hist_d  = v;
    prime_d = cfg_we_i;
    event_d = hit & cfg_q.en & ~freeze_i;
    if (cfg_we_i) begin
      cfg_d = cfg_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q   <= '0;
      hist_q  <= 1'b0;
      prime_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      hist_q  <= hist_d;
      prime_q <= prime_d;
      event_q <= event_d;
    end
  end

  assign cfg_o   = cfg_q;
  assign event_o = event_q;

endmodule

// File: rtl/perf_event_select.sv
// Programmable event router in front of the performance counters:
// source register, CTRL, IO decode and registered read-back.
module perf_event_select
  import perf_pkg::*;
#(
  parameter int          NUM_SOURCES  = 32,
  parameter int          NUM_COUNTERS = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SOURCES-1:0]  perf_sources,
  output logic [NUM_COUNTERS-1:0] perf_events,
  input  logic [31:0]             io_address,
  input  logic                    io_write_en,
  input  logic [31:0]             io_write_data,
  input  logic                    io_read_en,
  output logic [31:0]             io_read_data
);

  localparam int IDX_W = 32 - $clog2(PERF_REG_STRIDE);
  localparam int OFS_W = $clog2(PERF_REG_STRIDE);

  logic [NUM_SOURCES-1:0]  src_q, src_d;
  logic                    freeze_q, freeze_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [31:0]             offset;
  logic [IDX_W-1:0]        word_idx;
  logic                    aligned;
  logic [NUM_COUNTERS-1:0] cfg_hit;
  logic [NUM_COUNTERS-1:0] cfg_we;
  logic                    ctrl_hit;
  logic [31:0]             rd_mux;
  perf_cfg_t               cfg_wdata;
  perf_cfg_t               cfg_arr [NUM_COUNTERS];

  logic                    unused_wdata;

  // Addresses below BASE wrap to a huge offset and decode as unmapped.
  assign offset   = io_address - BASE_ADDRESS;
  assign word_idx = offset[31:OFS_W];
  assign aligned  = (offset[OFS_W-1:0] == '0);
  assign ctrl_hit = aligned &&
                    (word_idx == IDX_W'(NUM_COUNTERS));

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_dec
    assign cfg_hit[i] = aligned &&
                        (word_idx == IDX_W'(i));
    assign cfg_we[i]  = io_write_en & cfg_hit[i];
  end

  assign cfg_wdata =
    perf_cfg_from_word(io_write_data[PERF_CFG_W-1:0]);

  assign unused_wdata = ^io_write_data[31:PERF_CFG_W];

  always_comb begin
    src_d    = perf_sources;
    freeze_d = freeze_q;
    if (io_write_en && ctrl_hit) begin
      freeze_d = io_write_data[PERF_CTRL_FREEZE_BIT];
    end
  end

  // Mux samples current state, so a same-cycle write reads old data.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (cfg_hit[i]) begin
        rd_mux = perf_cfg_word(cfg_arr[i]);
      end
    end
    if (ctrl_hit) begin
      rd_mux[PERF_CTRL_FREEZE_BIT] = freeze_q;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (io_read_en) begin
      rdata_d = rd_mux;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q    <= '0;
      freeze_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      src_q    <= src_d;
      freeze_q <= freeze_d;
      rdata_q  <= rdata_d;
    end
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ch
    perf_event_channel #(
      .NUM_SOURCES (NUM_SOURCES)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (reset),
      .src_i       (src_q),
      .cfg_we_i    (cfg_we[i]),
      .cfg_wdata_i (cfg_wdata),
      .freeze_i    (freeze_q),
      .cfg_o       (cfg_arr[i]),
      .event_o     (perf_events[i])
    );
  end

  assign io_read_data = rdata_q;

endmodule

// File: tb/tb_perf_event_select.sv
// Directed bench for perf_event_select: per-cycle vector tables
// plus hand-written sequences for prime, freeze, IO and reset.
module tb_perf_event_select;

  localparam int NS = 32;
  localparam int NC = 4;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] CTRL = BASE + 32'(4 * NC);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NS-1:0] perf_sources = '0;
  logic [NC-1:0] perf_events;
  logic [31:0]   io_address = '0;
  logic          io_write_en = 1'b0;
  logic [31:0]   io_write_data = '0;
  logic          io_read_en = 1'b0;
  logic [31:0]   io_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] src;
    logic [3:0]  ev;
  } vec_t;

  vec_t tab[$];

  perf_event_select #(
    .NUM_SOURCES  (NS),
    .NUM_COUNTERS (NC),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .perf_sources  (perf_sources),
    .perf_events   (perf_events),
    .io_address    (io_address),
    .io_write_en   (io_write_en),
    .io_write_data (io_write_data),
    .io_read_en    (io_read_en),
    .io_read_data  (io_read_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic io_wr(input logic [31:0] a,
                       input logic [31:0] d);
    io_address    = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    tick();
    io_write_en   = 1'b0;
  endtask

  task automatic io_rd(input  logic [31:0] a,
                       output logic [31:0] d);
    io_address = a;
    io_read_en = 1'b1;
    tick();
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  // Entry k: drive src, clock once, expect ev.
  task automatic run_tab(input string nm);
    foreach (tab[k]) begin
      perf_sources = tab[k].src;
      tick();
      check($sformatf("%s[%0d]", nm, k),
            32'(perf_events), 32'(tab[k].ev));
    end
  endtask

  logic [31:0] rd;

  initial begin
    // Reset held with sources toggling
    for (int i = 0; i < 4; i++) begin
      perf_sources = $urandom;
      tick();
      check("rst_events", 32'(perf_events), 32'h0);
    end
    check("rst_rdata", io_read_data, 32'h0);
    reset = 1'b1;
    perf_sources = '0;
    tick();
    tick();
    for (int i = 0; i <= NC; i++) begin
      io_rd(BASE + 32'(4 * i), rd);
      check($sformatf("rst_reg%0d", i), rd, 32'h0);
    end

    // Level: sel=5, three cycles high
    io_wr(BASE + 32'h0, 32'h105);
    tab = '{
      '{32'h20, 4'h0},
      '{32'h20, 4'h1},
      '{32'h20, 4'h1},
      '{32'h00, 4'h1},
      '{32'h00, 4'h0},
      '{32'h00, 4'h0}
    };
    run_tab("level");

    // Edge: sel=3, ten cycles high -> one pulse
    io_wr(BASE + 32'h4, 32'h303);
    tab = '{
      '{32'h8, 4'h0}, '{32'h8, 4'h2},
      '{32'h8, 4'h0}, '{32'h8, 4'h0},
      '{32'h8, 4'h0}, '{32'h8, 4'h0},
      '{32'h8, 4'h0}, '{32'h8, 4'h0},
      '{32'h8, 4'h0}, '{32'h8, 4'h0},
      '{32'h0, 4'h0}, '{32'h0, 4'h0}
    };
    run_tab("edge");

    // Retarget onto an already-high source: no fake edge
    perf_sources = 32'h10;
    tick();
    tick();
    io_wr(BASE + 32'h4, 32'h304);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("retarget", 32'(perf_events), 32'h0);
    end

    // Rewrite while selected source is high
    perf_sources = 32'h18;
    tick();
    io_wr(BASE + 32'h4, 32'h303);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rewrite", 32'(perf_events), 32'h0);
    end

    // Invert with out-of-range select
    perf_sources = '0;
    tick();
    tick();
    io_wr(BASE + 32'h8, 32'h5FF);
    tick();
    check("inv_prime", 32'(perf_events), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("inv_const1", 32'(perf_events), 32'h4);
    end
    io_wr(BASE + 32'h8, 32'h1FF);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("range_const0", 32'(perf_events), 32'h0);
    end

    // Freeze with an edge channel whose source rises while frozen
    perf_sources = 32'h7;
    io_wr(BASE + 32'h0, 32'h100);
    io_wr(BASE + 32'h4, 32'h101);
    io_wr(BASE + 32'h8, 32'h102);
    io_wr(BASE + 32'hC, 32'h303);
    tick();
    tick();
    check("pre_freeze", 32'(perf_events), 32'h7);
    io_wr(CTRL, 32'h1);
    check("freeze_lag", 32'(perf_events), 32'h7);
    tick();
    check("freeze_on", 32'(perf_events), 32'h0);
    perf_sources = 32'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frozen", 32'(perf_events), 32'h0);
    end
    io_rd(CTRL, rd);
    check("ctrl_rd", rd, 32'h1);
    io_wr(CTRL, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("unfreeze", 32'(perf_events), 32'h7);
    end

    // Simultaneous read and write of CFG[3]
    io_address    = BASE + 32'hC;
    io_write_data = 32'h107;
    io_write_en   = 1'b1;
    io_read_en    = 1'b1;
    tick();
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    check("rw_old", io_read_data, 32'h303);
    io_rd(BASE + 32'hC, rd);
    check("rw_new", rd, 32'h107);
    io_address = BASE + 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_hold", io_read_data, 32'h107);
    end
    io_rd(BASE + 32'h100, rd);
    check("rd_unmapped", rd, 32'h0);
    io_wr(BASE + 32'h100, 32'h7FF);
    io_wr(CTRL + 32'h4, 32'h1);
    io_rd(BASE + 32'h8, rd);
    check("wr_unmapped", rd, 32'h102);
    io_wr(CTRL, 32'hFFFF_FFFE);
    io_rd(CTRL, rd);
    check("ctrl_bits", rd, 32'h0);
    tick();
    check("ctrl_nofrz", 32'(perf_events), 32'h7);

    // Asynchronous reset mid-operation
    io_rd(BASE + 32'h8, rd);
    check("pre_rst_rd", rd, 32'h102);
    #3;
    reset = 1'b0;
    #1;
    check("async_ev", 32'(perf_events), 32'h0);
    check("async_rd", io_read_data, 32'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst", 32'(perf_events), 32'h0);
    end
    io_rd(BASE + 32'h0, rd);
    check("post_rst_cfg", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
